stbc_encoder: RTL and testbench

//  Transmit-side Alamouti space-time block encoder; the SOML decoder chain consumes the codewords it builds.

---
 rtl/stbc_pkg.sv | 57 +++++
 rtl/stbc_encoder_if.sv | 33 +++
 rtl/stbc_cneg.sv | 29 ++
 rtl/stbc_encoder.sv | 125 ++++++++++++
 tb/tb_stbc_encoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/stbc_pkg.sv
// +----------------------------------------------------------------------------+
// | stbc_pkg : shared widths, constants and saturating helpers for stbc_encoder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package stbc_pkg;

  localparam int STBC_W       = 16;
  localparam int STBC_Q       = 8;
  localparam int INV_SQRT2_Q8 = 181;

  localparam logic signed [STBC_W-1:0] COMP_MAX = {1'b0, {(STBC_W-1){1'b1}}};
  localparam logic signed [STBC_W-1:0] COMP_MIN = {1'b1, {(STBC_W-1){1'b0}}};

  localparam logic signed [STBC_W+9:0] WIDE_MAX = (STBC_W+10)'(2**(STBC_W-1) - 1);
  localparam logic signed [STBC_W+9:0] WIDE_MIN = (STBC_W+10)'(-(2**(STBC_W-1)));
  localparam logic signed [STBC_W+9:0] SCALE_K  = (STBC_W+10)'(INV_SQRT2_Q8);
  localparam logic signed [STBC_W+9:0] ROUND_K  = (STBC_W+10)'(1 << (STBC_Q-1));

  typedef struct packed {
    logic signed [STBC_W-1:0] r;
    logic signed [STBC_W-1:0] i;
  } cplx_t;

  typedef struct packed {
    logic                     sat;
    logic signed [STBC_W-1:0] v;
  } sat_t;

  function automatic sat_t sat_neg(input logic signed [STBC_W-1:0] v);
    sat_t res;
    res.sat = (v == COMP_MIN);
    res.v   = res.sat ? COMP_MAX : -v;
    return res;
  endfunction

  // Round-half-up multiply by 1/sqrt(2) in Q8, clamped back to W bits.
  function automatic sat_t sat_round(input logic signed [STBC_W-1:0] v);
    logic signed [STBC_W+9:0] p;
    sat_t res;
    p = ($signed({{10{v[STBC_W-1]}}, v}) * SCALE_K + ROUND_K) >>> STBC_Q;
    res.sat = 1'b0;
    res.v   = p[STBC_W-1:0];
    if (p > WIDE_MAX) begin
      res.sat = 1'b1;
      res.v   = COMP_MAX;
    end else if (p < WIDE_MIN) begin
      res.sat = 1'b1;
      res.v   = COMP_MIN;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stbc_encoder_if.sv
// +----------------------------------------------------------------------------+
// | stbc_encoder_if : symbol-in / codeword-slot-out handshake bundle            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface stbc_encoder_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_r;
  logic signed [W-1:0] in_i;
  logic                out_valid;
  logic                out_ready;
  logic                out_slot;
  logic signed [W-1:0] out_a0_r;
  logic signed [W-1:0] out_a0_i;
  logic signed [W-1:0] out_a1_r;
  logic signed [W-1:0] out_a1_i;

  // master: symbol source and slot sink; slave: the encoder itself
  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_slot, out_a0_r, out_a0_i, out_a1_r, out_a1_i
  );
  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_slot, out_a0_r, out_a0_i, out_a1_r, out_a1_i
  );
endinterface

`default_nettype wire

// File: rtl/stbc_cneg.sv
// +----------------------------------------------------------------------------+
// | stbc_cneg : saturating conj(x) or -conj(x) of one complex value             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stbc_cneg
  import stbc_pkg::*;
(
  input  cplx_t i_x,
  input  logic  i_neg_real,
  output cplx_t o_y,
  output logic  o_sat
);

  sat_t w_nr;
  sat_t w_ni;

  assign w_nr = sat_neg(i_x.r);
  assign w_ni = sat_neg(i_x.i);

  // -conj(x) = (-r, i); conj(x) = (r, -i)
  assign o_y.r = i_neg_real ? w_nr.v : i_x.r;
  assign o_y.i = i_neg_real ? i_x.i  : w_ni.v;
  assign o_sat = i_neg_real ? w_nr.sat : w_ni.sat;

endmodule

`default_nettype wire

// File: rtl/stbc_encoder.sv
// +----------------------------------------------------------------------------+
// | stbc_encoder : double-buffered Alamouti 2x2 encoder; optional 1/sqrt(2)     |
// | output scaling when STBC_SCALE_EN is defined.  Rev 1.0                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module stbc_encoder
  import stbc_pkg::*;
#(
  parameter int W = STBC_W,
  parameter int Q = STBC_Q
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  stbc_encoder_if.slave        bus,
  output logic                 sat_flag
);

  if (W != STBC_W || Q != STBC_Q) begin : g_param_check
    $error("stbc_encoder: W/Q must match the stbc_pkg format");
  end

  cplx_t      r_s1 [2];
  cplx_t      r_s2 [2];
  logic [1:0] r_full;
  logic       r_wbank, r_wslot, r_rbank, r_rslot;
  logic       r_out_valid, r_out_slot, r_sat;
  cplx_t      r_a0, r_a1;

  logic [1:0] w_full_nxt;
  logic       w_in_fire, w_load;
  cplx_t      w_in, w_rs1, w_rs2;
  cplx_t      w_neg_s2, w_conj_s1, w_pre_a0, w_pre_a1, w_nxt_a0, w_nxt_a1;
  logic       w_sat_a0, w_sat_a1, w_pre_sat, w_nxt_sat;

  assign bus.in_ready = ~r_full[r_wbank];
  // flush wins over any same-cycle symbol
  assign w_in_fire    = bus.in_valid & ~r_full[r_wbank] & ~flush;
  assign w_load       = r_full[r_rbank] & (~r_out_valid | bus.out_ready);
  assign w_in         = '{r: bus.in_r, i: bus.in_i};
  assign w_rs1        = r_s1[r_rbank];
  assign w_rs2        = r_s2[r_rbank];

  stbc_cneg u_neg_conj_s2 (.i_x(w_rs2), .i_neg_real(1'b1), .o_y(w_neg_s2),  .o_sat(w_sat_a0));
  stbc_cneg u_conj_s1     (.i_x(w_rs1), .i_neg_real(1'b0), .o_y(w_conj_s1), .o_sat(w_sat_a1));

  assign w_pre_a0  = r_rslot ? w_neg_s2  : w_rs1;
  assign w_pre_a1  = r_rslot ? w_conj_s1 : w_rs2;
  assign w_pre_sat = r_rslot & (w_sat_a0 | w_sat_a1);

`ifdef STBC_SCALE_EN
  sat_t w_sc [4];
  assign w_sc[0]   = sat_round(w_pre_a0.r);
  assign w_sc[1]   = sat_round(w_pre_a0.i);
  assign w_sc[2]   = sat_round(w_pre_a1.r);
  assign w_sc[3]   = sat_round(w_pre_a1.i);
  assign w_nxt_a0  = '{r: w_sc[0].v, i: w_sc[1].v};
  assign w_nxt_a1  = '{r: w_sc[2].v, i: w_sc[3].v};
  assign w_nxt_sat = w_pre_sat | w_sc[0].sat | w_sc[1].sat | w_sc[2].sat | w_sc[3].sat;
`else
  assign w_nxt_a0  = w_pre_a0;
  assign w_nxt_a1  = w_pre_a1;
  assign w_nxt_sat = w_pre_sat;
`endif

  // Set and clear never hit the same bank: a full bank is never the write bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_in_fire && r_wslot) w_full_nxt[r_wbank] = 1'b1;
    if (w_load && r_rslot)    w_full_nxt[r_rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      if (r_wslot) r_s2[r_wbank] <= w_in;
      else         r_s1[r_wbank] <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full      <= 2'b00;
      r_wbank     <= 1'b0;
      r_wslot     <= 1'b0;
      r_rbank     <= 1'b0;
      r_rslot     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_slot  <= 1'b0;
      r_a0        <= '0;
      r_a1        <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (flush) begin
        r_wslot <= 1'b0;
      end else if (w_in_fire) begin
        r_wslot <= ~r_wslot;
        if (r_wslot) r_wbank <= ~r_wbank;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_slot  <= r_rslot;
        r_a0        <= w_nxt_a0;
        r_a1        <= w_nxt_a1;
        r_rslot     <= ~r_rslot;
        if (r_rslot) r_rbank <= ~r_rbank;
        if (w_nxt_sat) r_sat <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_slot  = r_out_slot;
  assign bus.out_a0_r  = r_a0.r;
  assign bus.out_a0_i  = r_a0.i;
  assign bus.out_a1_r  = r_a1.r;
  assign bus.out_a1_i  = r_a1.i;
  assign sat_flag      = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_stbc_encoder.sv
// +----------------------------------------------------------------------------+
// | tb_stbc_encoder : directed scoreboard bench for stbc_encoder                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stbc_encoder;

  typedef struct packed {
    logic        slot;
    logic [15:0] a0r;
    logic [15:0] a0i;
    logic [15:0] a1r;
    logic [15:0] a1i;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        sat_flag;
  int          checks = 0;
  int          errors = 0;
  slot_t       sbq[$];
  logic        have_s1;
  logic [15:0] s1r, s1i;

  stbc_encoder_if #(.W(16)) bus ();

  stbc_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] neg(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    return -v;
  endfunction

  function automatic logic [15:0] scl(input logic [15:0] v);
`ifdef STBC_SCALE_EN
    int x;
    x = $signed(v);
    x = (x * 181 + 128) >>> 8;
    if (x > 32767)  x = 32767;
    if (x < -32768) x = -32768;
    return x[15:0];
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [15:0] r, input logic [15:0] i);
    if (!have_s1) begin
      s1r = r; s1i = i; have_s1 = 1'b1;
    end else begin
      sbq.push_back('{1'b0, scl(s1r), scl(s1i), scl(r), scl(i)});
      sbq.push_back('{1'b1, scl(neg(r)), scl(i), scl(s1r), scl(neg(s1i))});
      have_s1 = 1'b0;
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send(input logic [15:0] r, input logic [15:0] i);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_r = r; bus.in_i = i;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    else model_accept(r, i);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush(input logic with_data, input logic [15:0] r, input logic [15:0] i);
    flush = 1'b1;
    bus.in_valid = with_data; bus.in_r = r; bus.in_i = i;
    have_s1 = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      slot_t obs;
      slot_t exp;
      obs = '{bus.out_slot, bus.out_a0_r, bus.out_a0_i, bus.out_a1_r, bus.out_a1_i};
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_slot observed=%h expected=none", obs);
      end
      if (sbq.size() > 0) begin
        exp = sbq.pop_front();
        checks++;
        assert (obs === exp) else begin
          errors++;
          $error("FAIL slot observed=%h expected=%h", obs, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; have_s1 = 1'b0; s1r = '0; s1i = '0;
    bus.in_valid = 1'b0; bus.in_r = '0; bus.in_i = '0; bus.out_ready = 1'b1;

    // reset state
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_a0_r", 32'(bus.out_a0_r), 32'd0);
    chk("rst_a1_i", 32'(bus.out_a1_i), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // basic pair
    send(16'h0100, 16'h0080);
    send(16'hFE00, 16'h0040);
    wait_drain();
    chk("sat_clean", 32'(sat_flag), 32'd0);

    // saturating negation, then sticky through a clean pair
    send(16'h0100, 16'h0000);
    send(16'h8000, 16'h0010);
    wait_drain();
    chk("sat_set", 32'(sat_flag), 32'd1);
    send(16'h0200, 16'h0300);
    send(16'h0050, 16'hFF00);
    wait_drain();
    chk("sat_sticky", 32'(sat_flag), 32'd1);

    // backpressure: four symbols fill both banks
    bus.out_ready = 1'b0;
    send(16'h0001, 16'h0002);
    send(16'h0003, 16'h0004);
    send(16'h0005, 16'h0006);
    send(16'h0007, 16'h0008);
    @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_out_slot", 32'(bus.out_slot), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16'h0009, 16'h000A);
    send(16'h000B, 16'h000C);
    wait_drain();

    // flush discards a lone s1, and beats a same-cycle s2
    send(16'h1111, 16'h2222);
    do_flush(1'b0, 16'h0000, 16'h0000);
    send(16'h0300, 16'h0400);
    send(16'h0500, 16'h0600);
    wait_drain();
    send(16'h0700, 16'h0800);
    do_flush(1'b1, 16'h0900, 16'h0A00);
    send(16'h0B00, 16'h0C00);
    send(16'h0D00, 16'h0E00);
    wait_drain();

    // reset while slot0 is stalled
    bus.out_ready = 1'b0;
    send(16'h0123, 16'h0456);
    send(16'h0789, 16'h0ABC);
    begin
      int n = 0;
      while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    end
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_slot", 32'(bus.out_slot), 32'd0);
    chk("mid_rst_a0", {bus.out_a0_r, bus.out_a0_i}, 32'd0);
    chk("mid_rst_a1", {bus.out_a1_r, bus.out_a1_i}, 32'd0);
    chk("mid_rst_sat", 32'(sat_flag), 32'd0);
    sbq.delete();
    have_s1 = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    send(16'h0010, 16'h0020);
    send(16'h0030, 16'h0040);
    wait_drain();

    // scaling reference value (unscaled in the default build)
    send(16'h0100, 16'h0000);
    send(16'h0000, 16'h0000);
    wait_drain();

    // continuous stream: no output bubbles
    fork
      begin
        for (int k = 0; k < 8; k++) send(16'(k * 16'h0101), 16'(16'hF000 + k));
      end
      begin
        int n = 0;
        int bub = 0;
        while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
        for (int k = 0; k < 8; k++) begin
          if (!bus.out_valid) bub++;
          @(negedge clk);
        end
        chk("stream_bubbles", 32'(bub), 32'd0);
      end
    join
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
